uart_tx_module: RTL and testbench
=================================

Name: uart_tx_module

Overview:
UART transmitter. It serialises one byte per request into a standard asynchronous frame on the TX line.
- Frame: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Contains its own bit-period timing, counted in CLK cycles.
- Sits opposite the UART receive path. Driven by the system-level control FSM through a single-cycle request / done handshake.

Parameters:
- BPS_DIV, 5208, CLK cycles per bit period (50 MHz / 9600 baud); legal range 4..8191.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd; value 3 is treated as none.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- CLK  input  1  system clock, all logic rising-edge.
- RSTn  input  1  asynchronous active-low reset.
- En_Sig  input  1  transmit request; sampled only when idle.
- TX_Data  input  8  byte to send; sampled in the same cycle as an accepted En_Sig.
- TX_Pin_Out  output  1  serial line, idle high.
- Busy_Sig  output  1  high while a frame is in progress.
- Done_Sig  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (asynchronous, immediate, including mid-frame):
  - TX_Pin_Out=1, Busy_Sig=0, Done_Sig=0.
  - State=IDLE, bit counter=0, shift register=0.
  - The frame is abandoned, with no Done_Sig.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_Pin_Out=1, Busy_Sig=0.
  - On En_Sig=1 at a rising edge: latch TX_Data, compute the parity bit, clear the bit counter, go to START.
  - At that same edge Busy_Sig→1 and TX_Pin_Out→0. Latency from request edge to line low is 1 clock.
- Bit timing: 13-bit counter runs 0..BPS_DIV-1 within each bit, then wraps to 0. Every bit is held for exactly BPS_DIV clocks. The bit-end strobe is asserted when counter==BPS_DIV-1.
- START: drive 0. On strobe go to DATA with bit index 0.
- DATA:
  - Drive shift[0]; on strobe shift right and increment the index.
  - After index 7's strobe: go to PARITY if PARITY_MODE is 1 or 2, else STOP.
- PARITY:
  - Even mode drives XOR of the 8 bits.
  - Odd mode drives its inverse.
  - On strobe go to STOP.
- STOP:
  - Drive 1 for STOP_BITS bit periods.
  - On the final strobe go to IDLE, pulse Done_Sig for exactly 1 cycle, and drop Busy_Sig, both on that same edge.
- Frame length: BPS_DIV*(10+P+(STOP_BITS-1)) clocks, P=1 if parity is enabled.
- En_Sig and TX_Data are ignored while Busy_Sig=1. There is no queuing and no error flag.
- Back-to-back: En_Sig held high through the Done_Sig cycle is accepted in that cycle. The stop bit is full length, then the line goes low on the next edge.
- TX_Data changing after acceptance has no effect on the frame in progress.
- All outputs are registered; no combinational path from inputs to TX_Pin_Out.

Decomposition:
- Shared package holds:
  - constant BPS_DIV_9600=5208, with BPS_DIV_115200=434 alongside;
  - PARITY_NONE/EVEN/ODD encodings;
  - TX state encoding, 3 bits.
- One natural sub-module: tx_bps_module.
  - Holds the bit-period counter.
  - Input Count_Sig (the counter is enabled while Busy).
  - Output BPS_CLK, the end-of-bit strobe at BPS_DIV-1.
  - Clears to 0 when Count_Sig is low.
- The FSM, shift register and parity logic stay in uart_tx_module.

Test Plan:
- Reset/idle: hold RSTn=0 then release, no request for 100 clocks → TX_Pin_Out=1, Busy_Sig=0, Done_Sig never asserted.
- Basic frame: BPS_DIV=16, PARITY_MODE=0, send 8'hA5. Line sampled at bit centres reads 0,1,0,1,0,0,1,0,1,1. Done_Sig is a single pulse exactly 160 clocks after the request edge.
- Parity and stop bits:
  - PARITY_MODE=1, send 8'h07 → parity bit 1.
  - PARITY_MODE=2, same byte → parity bit 0.
  - STOP_BITS=2 → line high for 32 clocks before Done_Sig; total 192 clocks.
- Busy rejection and back-to-back:
  - Pulse En_Sig with 8'h11 mid-frame of 8'h3C → ignored; only 8'h3C is transmitted.
  - Then hold En_Sig=1 with 8'h55 → second frame starts the cycle after Done_Sig, with no extra idle bits.
- Reset mid-frame: assert RSTn=0 during data bit 4 → TX_Pin_Out=1 immediately, with no Done_Sig. After release, a new request sends a correct full frame.
- Default divider: BPS_DIV=5208, send 8'h00 → start plus data low for 46872 clocks, stop high 5208 clocks, Done_Sig at clock 52080.

Source files
------------

// File: rtl/uart_tx_module_pkg.sv
// Shared constants, state encoding and parity helpers for the UART transmitter.
package uart_tx_module_pkg;

  localparam int unsigned BPS_DIV_9600   = 5208;
  localparam int unsigned BPS_DIV_115200 = 434;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

  function automatic logic parity_en(input int unsigned mode);
    return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
  endfunction

  function automatic logic parity_bit(input int unsigned mode, input logic [7:0] data);
    return (mode == PARITY_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_module_bps.sv
// Bit-period counter: runs 0..BPS_DIV-1 while enabled and strobes on the last count.
module tx_bps_module #(
  parameter int unsigned BPS_DIV = 5208
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic Count_Sig,
  output logic BPS_CLK
);

  localparam logic [12:0] CntMax = 13'(BPS_DIV - 1);

  logic [12:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!Count_Sig) begin
      cnt_d = 13'd0;
    end else if (cnt_q == CntMax) begin
      cnt_d = 13'd0;
    end else begin
      cnt_d = cnt_q + 13'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q <= 13'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign BPS_CLK = Count_Sig && (cnt_q == CntMax);

endmodule

// File: rtl/uart_tx_module.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_module
  import uart_tx_module_pkg::*;
#(
  parameter int unsigned BPS_DIV     = BPS_DIV_9600,
  parameter int unsigned PARITY_MODE = PARITY_NONE,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       En_Sig,
  input  logic [7:0] TX_Data,
  output logic       TX_Pin_Out,
  output logic       Busy_Sig,
  output logic       Done_Sig
);

  localparam logic ParEn    = parity_en(PARITY_MODE);
  localparam logic StopLast = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       par_q, par_d;
  logic       stop_q, stop_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       bps_clk;

  tx_bps_module #(
    .BPS_DIV(BPS_DIV)
  ) u_bps (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .Count_Sig(busy_q),
    .BPS_CLK  (bps_clk)
  );

  // tx_d is the level for the bit being entered, so the line changes on the same edge as state.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (En_Sig) begin
          shift_d = TX_Data;
          par_d   = parity_bit(PARITY_MODE, TX_Data);
          idx_d   = 3'd0;
          stop_d  = 1'b0;
          state_d = StStart;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (bps_clk) begin
          state_d = StData;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (bps_clk) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            if (ParEn) begin
              state_d = StParity;
              tx_d    = par_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
      StParity: begin
        if (bps_clk) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (bps_clk) begin
          if (stop_q == StopLast) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= StIdle;
      shift_q <= 8'd0;
      idx_q   <= 3'd0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign TX_Pin_Out = tx_q;
  assign Busy_Sig   = busy_q;
  assign Done_Sig   = done_q;

endmodule

// File: tb/tb_uart_tx_module.sv
// Bench for uart_tx_module: five parameterisations, expected line bits queued per frame.
module tb_uart_tx_module;

  localparam int NDut = 5;

  function automatic int div_of(input int k);
    return (k == 4) ? 5208 : 16;
  endfunction

  function automatic int par_of(input int k);
    case (k)
      1, 3:    return 1;
      2:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int stop_of(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       en     [NDut];
  logic [7:0] dat    [NDut];
  logic       tx_w   [NDut];
  logic       busy_w [NDut];
  logic       done_w [NDut];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    uart_tx_module #(
      .BPS_DIV    (div_of(g)),
      .PARITY_MODE(par_of(g)),
      .STOP_BITS  (stop_of(g))
    ) u_dut (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .En_Sig    (en[g]),
      .TX_Data   (dat[g]),
      .TX_Pin_Out(tx_w[g]),
      .Busy_Sig  (busy_w[g]),
      .Done_Sig  (done_w[g])
    );
  end

  typedef struct {
    int       k;
    logic [7:0] d;
    logic     has_par;
    logic     par;
    int       stops;
    int       len;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  logic exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input logic has_par, input logic par,
                            input int stops);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (has_par) exp_q.push_back(par);
    for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
  endtask

  // Called right after the request edge; c counts whole cycles since that edge.
  task automatic monitor_frame(input int k, input int len);
    int   b;
    int   early;
    int   busy_bad;
    logic cur;
    b        = div_of(k);
    early    = 0;
    busy_bad = 0;
    cur      = 1'b1;
    for (int c = 0; c <= len; c++) begin
      @(negedge CLK);
      if (c < len) begin
        if (c % b == 0) begin
          if (exp_q.size() == 0) begin
            check("scoreboard underrun", 32'd1, 32'd0);
          end else begin
            cur = exp_q.pop_front();
          end
          check($sformatf("dut%0d bit%0d start", k, c / b), 32'(tx_w[k]), 32'(cur));
        end else if (c % b == b / 2) begin
          check($sformatf("dut%0d bit%0d centre", k, c / b), 32'(tx_w[k]), 32'(cur));
        end else if (c % b == b - 1) begin
          check($sformatf("dut%0d bit%0d end", k, c / b), 32'(tx_w[k]), 32'(cur));
        end
        if (done_w[k] !== 1'b0) early++;
        if (busy_w[k] !== 1'b1) busy_bad++;
      end else begin
        check($sformatf("dut%0d done at end", k), 32'(done_w[k]), 32'd1);
        check($sformatf("dut%0d busy drop", k), 32'(busy_w[k]), 32'd0);
        check($sformatf("dut%0d line idle", k), 32'(tx_w[k]), 32'd1);
      end
    end
    check($sformatf("dut%0d early done", k), 32'(early), 32'd0);
    check($sformatf("dut%0d busy held", k), 32'(busy_bad), 32'd0);
    check($sformatf("dut%0d queue drained", k), 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    push_frame(v.d, v.has_par, v.par, v.stops);
    @(negedge CLK);
    en[v.k]  = 1'b1;
    dat[v.k] = v.d;
    @(posedge CLK);
    fork
      monitor_frame(v.k, v.len);
      begin
        @(negedge CLK);
        en[v.k]  = 1'b0;
        dat[v.k] = 8'($urandom);
      end
    join
    @(negedge CLK);
    check($sformatf("dut%0d done one cycle", v.k), 32'(done_w[v.k]), 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int idle_done  [NDut];
    int idle_low   [NDut];
    int idle_busy  [NDut];

    vecs[0] = '{k: 0, d: 8'hA5, has_par: 1'b0, par: 1'b0, stops: 1, len: 160};
    vecs[1] = '{k: 1, d: 8'h07, has_par: 1'b1, par: 1'b1, stops: 1, len: 176};
    vecs[2] = '{k: 2, d: 8'h07, has_par: 1'b1, par: 1'b0, stops: 1, len: 176};
    vecs[3] = '{k: 3, d: 8'h07, has_par: 1'b1, par: 1'b1, stops: 2, len: 192};
    vecs[4] = '{k: 1, d: 8'hFF, has_par: 1'b1, par: 1'b0, stops: 1, len: 176};
    vecs[5] = '{k: 2, d: 8'h80, has_par: 1'b1, par: 1'b0, stops: 1, len: 176};
    vecs[6] = '{k: 4, d: 8'h00, has_par: 1'b0, par: 1'b0, stops: 1, len: 52080};

    for (int k = 0; k < NDut; k++) begin
      en[k]        = 1'b0;
      dat[k]       = 8'h00;
      idle_done[k] = 0;
      idle_low[k]  = 0;
      idle_busy[k] = 0;
    end
    RSTn = 1'b0;
    repeat (4) @(negedge CLK);
    RSTn = 1'b1;

    // Idle after reset: no request for 100 clocks.
    repeat (100) begin
      @(negedge CLK);
      for (int k = 0; k < NDut; k++) begin
        if (done_w[k] !== 1'b0) idle_done[k]++;
        if (tx_w[k] !== 1'b1) idle_low[k]++;
        if (busy_w[k] !== 1'b0) idle_busy[k]++;
      end
    end
    for (int k = 0; k < NDut; k++) begin
      check($sformatf("dut%0d idle done", k), 32'(idle_done[k]), 32'd0);
      check($sformatf("dut%0d idle line", k), 32'(idle_low[k]), 32'd0);
      check($sformatf("dut%0d idle busy", k), 32'(idle_busy[k]), 32'd0);
    end

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Busy rejection then back-to-back on dut0.
    push_frame(8'h3C, 1'b0, 1'b0, 1);
    @(negedge CLK);
    en[0]  = 1'b1;
    dat[0] = 8'h3C;
    @(posedge CLK);
    fork
      monitor_frame(0, 160);
      begin
        @(negedge CLK);
        en[0]  = 1'b0;
        dat[0] = 8'hE7;
        repeat (60) @(negedge CLK);
        en[0]  = 1'b1;
        dat[0] = 8'h11;
        @(negedge CLK);
        en[0]  = 1'b0;
        repeat (80) @(negedge CLK);
        en[0]  = 1'b1;
        dat[0] = 8'h55;
      end
    join
    push_frame(8'h55, 1'b0, 1'b0, 1);
    fork
      monitor_frame(0, 160);
      begin
        @(negedge CLK);
        en[0]  = 1'b0;
        dat[0] = 8'h00;
      end
    join
    @(negedge CLK);
    check("btb done one cycle", 32'(done_w[0]), 32'd0);

    // Reset during data bit 4 (frame bit 5), chosen with a low level on the line.
    @(negedge CLK);
    en[0]  = 1'b1;
    dat[0] = 8'h0F;
    @(posedge CLK);
    @(negedge CLK);
    en[0] = 1'b0;
    repeat (88) @(negedge CLK);
    check("pre-reset line", 32'(tx_w[0]), 32'd0);
    check("pre-reset busy", 32'(busy_w[0]), 32'd1);
    RSTn = 1'b0;
    #1;
    check("reset line", 32'(tx_w[0]), 32'd1);
    check("reset busy", 32'(busy_w[0]), 32'd0);
    check("reset done", 32'(done_w[0]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("in-reset done", 32'(done_w[0]), 32'd0);
    end
    RSTn = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1) check("post-reset idle", 32'd1, 32'd0);
    end
    run_vec('{k: 0, d: 8'hC3, has_par: 1'b0, par: 1'b0, stops: 1, len: 160});

    // Default divider frame.
    run_vec(vecs[6]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
